// File: rtl/writeback_regfile_if.sv
// Writeback-stage bundle: W-register inputs, decode read ports and processor status.
interface writeback_regfile_if;
  logic [3:0]  w_status;
  logic [3:0]  w_icode;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [3:0]  stat;
  logic        halted;
  logic [63:0] retired;

  modport master (
    output w_status, w_icode, w_dstE, w_dstM, w_valE, w_valM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, stat, halted, retired
  );

  modport slave (
    input  w_status, w_icode, w_dstE, w_dstM, w_valE, w_valM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, stat, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 style register file with writeback-stage status FSM and retired-instruction counter.
//
// state    | meaning
// RUN      | normal operation, writes and counting enabled
// STOP_HLT | stopped by a halt instruction
// STOP_ADR | stopped by an address fault
// STOP_INS | stopped by an illegal instruction or unknown status
module writeback_regfile (
  input logic                clk,
  input logic                rst,
  writeback_regfile_if.slave wb
);
  localparam logic [3:0] REG_NONE = 4'd15;
  localparam logic [3:0] ST_AOK   = 4'd1;
  localparam logic [3:0] ST_HLT   = 4'd2;
  localparam logic [3:0] ST_ADR   = 4'd3;
  localparam logic [3:0] ST_INS   = 4'd4;
  localparam logic [3:0] IC_NOP   = 4'd1;

  typedef enum logic [1:0] {RUN, STOP_HLT, STOP_ADR, STOP_INS} state_t;

  state_t      state, state_next;
  logic [63:0] regs [0:14];
  logic [63:0] retired_q;
  logic        enable, we_e, we_m, we_e_eff, count_en;

  assign enable   = (state == RUN) && (wb.w_status == ST_AOK);
  assign we_e     = enable && (wb.w_dstE != REG_NONE);
  assign we_m     = enable && (wb.w_dstM != REG_NONE);
  // valM wins when both ports target the same register (popq %rsp)
  assign we_e_eff = we_e && !(we_m && (wb.w_dstM == wb.w_dstE));
  assign count_en = enable && (wb.w_icode != IC_NOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == RUN) begin
      case (wb.w_status)
        ST_AOK:  state_next = RUN;
        ST_HLT:  state_next = STOP_HLT;
        ST_ADR:  state_next = STOP_ADR;
        ST_INS:  state_next = STOP_INS;
        default: state_next = STOP_INS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (we_e_eff) regs[wb.w_dstE] <= wb.w_valE;
      if (we_m)     regs[wb.w_dstM] <= wb.w_valM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired_q <= '0;
    else if (count_en) retired_q <= retired_q + 64'd1;
  end

  always_comb begin
    wb.d_rvalA = '0;
    if (wb.d_srcA != REG_NONE) begin
      if (we_m && (wb.d_srcA == wb.w_dstM))      wb.d_rvalA = wb.w_valM;
      else if (we_e && (wb.d_srcA == wb.w_dstE)) wb.d_rvalA = wb.w_valE;
      else                                       wb.d_rvalA = regs[wb.d_srcA];
    end
  end

  always_comb begin
    wb.d_rvalB = '0;
    if (wb.d_srcB != REG_NONE) begin
      if (we_m && (wb.d_srcB == wb.w_dstM))      wb.d_rvalB = wb.w_valM;
      else if (we_e && (wb.d_srcB == wb.w_dstE)) wb.d_rvalB = wb.w_valE;
      else                                       wb.d_rvalB = regs[wb.d_srcB];
    end
  end

  always_comb begin
    wb.stat = ST_AOK;
    case (state)
      RUN:      wb.stat = ST_AOK;
      STOP_HLT: wb.stat = ST_HLT;
      STOP_ADR: wb.stat = ST_ADR;
      STOP_INS: wb.stat = ST_INS;
      default:  wb.stat = ST_INS;
    endcase
  end

  assign wb.halted  = (state != RUN);
  assign wb.retired = retired_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: writes, bypass, status FSM, counter wrap and async reset.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  writeback_regfile_if bus ();

  writeback_regfile dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  task automatic set_w(input logic [3:0] status, input logic [3:0] icode,
                       input logic [3:0] dst_e, input logic [63:0] val_e,
                       input logic [3:0] dst_m, input logic [63:0] val_m);
    bus.w_status = status;
    bus.w_icode  = icode;
    bus.w_dstE   = dst_e;
    bus.w_valE   = val_e;
    bus.w_dstM   = dst_m;
    bus.w_valM   = val_m;
  endtask

  task automatic set_idle();
    set_w(4'd1, 4'd1, 4'd15, 64'd0, 4'd15, 64'd0);
  endtask

  // Advance one rising edge, then move to the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.d_srcA = 4'd3;
    bus.d_srcB = 4'd14;
    #1;
    n_checks++; if (bus.stat !== 4'd1) begin n_fail++; $display("FAIL reset_stat got %0d want 1", bus.stat); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0b want 0", bus.halted); end
    n_checks++; if (bus.retired !== 64'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", bus.retired); end
    n_checks++; if (bus.d_rvalA !== 64'd0) begin n_fail++; $display("FAIL reset_r3 got %0d want 0", bus.d_rvalA); end
    n_checks++; if (bus.d_rvalB !== 64'd0) begin n_fail++; $display("FAIL reset_r14 got %0d want 0", bus.d_rvalB); end
  endtask

  task automatic test_write();
    set_w(4'd1, 4'd3, 4'd3, 64'd100, 4'd15, 64'd0);
    bus.d_srcA = 4'd3;
    step();
    set_idle();
    #1;
    n_checks++; if (bus.d_rvalA !== 64'd100) begin n_fail++; $display("FAIL write_r3 got %0d want 100", bus.d_rvalA); end
    n_checks++; if (bus.retired !== 64'd1) begin n_fail++; $display("FAIL write_retired got %0d want 1", bus.retired); end
    // R14 is the highest storage register
    set_w(4'd1, 4'd2, 4'd14, 64'hDEAD_BEEF_0000_0001, 4'd15, 64'd0);
    step();
    set_idle();
    bus.d_srcB = 4'd14;
    #1;
    n_checks++; if (bus.d_rvalB !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL write_r14 got %h want deadbeef00000001", bus.d_rvalB); end
    n_checks++; if (bus.retired !== 64'd2) begin n_fail++; $display("FAIL write14_retired got %0d want 2", bus.retired); end
  endtask

  task automatic test_dual_write();
    set_w(4'd1, 4'd11, 4'd4, 64'd8, 4'd4, 64'd64);
    step();
    set_idle();
    bus.d_srcB = 4'd4;
    #1;
    n_checks++; if (bus.d_rvalB !== 64'd64) begin n_fail++; $display("FAIL dual_r4 got %0d want 64", bus.d_rvalB); end
    n_checks++; if (bus.retired !== 64'd3) begin n_fail++; $display("FAIL dual_retired got %0d want 3", bus.retired); end
  endtask

  task automatic test_bypass();
    set_w(4'd1, 4'd11, 4'd5, 64'd10, 4'd5, 64'd11);
    bus.d_srcA = 4'd5;
    bus.d_srcB = 4'd4;
    #1;
    n_checks++; if (bus.d_rvalA !== 64'd11) begin n_fail++; $display("FAIL bypass_m got %0d want 11", bus.d_rvalA); end
    n_checks++; if (bus.d_rvalB !== 64'd64) begin n_fail++; $display("FAIL bypass_other got %0d want 64", bus.d_rvalB); end
    step();
    set_w(4'd1, 4'd6, 4'd6, 64'h55, 4'd15, 64'd0);
    bus.d_srcB = 4'd6;
    #1;
    n_checks++; if (bus.d_rvalA !== 64'd11) begin n_fail++; $display("FAIL bypass_r5_stored got %0d want 11", bus.d_rvalA); end
    n_checks++; if (bus.d_rvalB !== 64'h55) begin n_fail++; $display("FAIL bypass_e got %h want 55", bus.d_rvalB); end
    step();
    set_idle();
    #1;
    n_checks++; if (bus.d_rvalB !== 64'h55) begin n_fail++; $display("FAIL bypass_r6_stored got %h want 55", bus.d_rvalB); end
    n_checks++; if (bus.retired !== 64'd5) begin n_fail++; $display("FAIL bypass_retired got %0d want 5", bus.retired); end
  endtask

  task automatic test_read_none();
    set_w(4'd1, 4'd6, 4'd15, 64'h77, 4'd15, 64'h88);
    bus.d_srcA = 4'd15;
    bus.d_srcB = 4'd15;
    #1;
    n_checks++; if (bus.d_rvalA !== 64'd0) begin n_fail++; $display("FAIL none_a got %h want 0", bus.d_rvalA); end
    n_checks++; if (bus.d_rvalB !== 64'd0) begin n_fail++; $display("FAIL none_b got %h want 0", bus.d_rvalB); end
    set_idle();
  endtask

  task automatic test_wrap();
    force dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_q;
    set_w(4'd1, 4'd3, 4'd15, 64'd0, 4'd15, 64'd0);
    step();
    set_idle();
    #1;
    n_checks++; if (bus.retired !== 64'd0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", bus.retired); end
    step();
    n_checks++; if (bus.retired !== 64'd0) begin n_fail++; $display("FAIL wrap_nop got %h want 0", bus.retired); end
    set_w(4'd1, 4'd3, 4'd15, 64'd0, 4'd15, 64'd0);
    step();
    set_idle();
    #1;
    n_checks++; if (bus.retired !== 64'd1) begin n_fail++; $display("FAIL wrap_next got %0d want 1", bus.retired); end
  endtask

  task automatic test_halt();
    set_w(4'd2, 4'd0, 4'd2, 64'd7, 4'd15, 64'd0);
    bus.d_srcA = 4'd2;
    step();
    set_w(4'd1, 4'd3, 4'd2, 64'd99, 4'd15, 64'd0);
    #1;
    n_checks++; if (bus.stat !== 4'd2) begin n_fail++; $display("FAIL halt_stat got %0d want 2", bus.stat); end
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got %0b want 1", bus.halted); end
    n_checks++; if (bus.d_rvalA !== 64'd0) begin n_fail++; $display("FAIL halt_no_bypass got %0d want 0", bus.d_rvalA); end
    n_checks++; if (bus.retired !== 64'd1) begin n_fail++; $display("FAIL halt_retired got %0d want 1", bus.retired); end
    step();
    set_idle();
    #1;
    n_checks++; if (bus.d_rvalA !== 64'd0) begin n_fail++; $display("FAIL halt_r2 got %0d want 0", bus.d_rvalA); end
    n_checks++; if (bus.retired !== 64'd1) begin n_fail++; $display("FAIL halt_retired2 got %0d want 1", bus.retired); end
    n_checks++; if (bus.stat !== 4'd2) begin n_fail++; $display("FAIL halt_sticky got %0d want 2", bus.stat); end
    bus.d_srcB = 4'd6;
    #1;
    n_checks++; if (bus.d_rvalB !== 64'h55) begin n_fail++; $display("FAIL halt_read got %h want 55", bus.d_rvalB); end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (bus.stat !== 4'd1) begin n_fail++; $display("FAIL rst1_stat got %0d want 1", bus.stat); end
    rst = 1'b0;
    set_w(4'd1, 4'd3, 4'd1, 64'd9, 4'd15, 64'd0);
    bus.d_srcA = 4'd1;
    step();
    set_w(4'd3, 4'd5, 4'd1, 64'd77, 4'd15, 64'd0);
    step();
    set_idle();
    #1;
    n_checks++; if (bus.stat !== 4'd3) begin n_fail++; $display("FAIL adr_stat got %0d want 3", bus.stat); end
    n_checks++; if (bus.d_rvalA !== 64'd9) begin n_fail++; $display("FAIL adr_r1 got %0d want 9", bus.d_rvalA); end
    n_checks++; if (bus.retired !== 64'd1) begin n_fail++; $display("FAIL adr_retired got %0d want 1", bus.retired); end
    // pulse reset well before the next rising edge
    rst = 1'b1;
    #2;
    n_checks++; if (bus.d_rvalA !== 64'd0) begin n_fail++; $display("FAIL arst_r1 got %0d want 0", bus.d_rvalA); end
    n_checks++; if (bus.stat !== 4'd1) begin n_fail++; $display("FAIL arst_stat got %0d want 1", bus.stat); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL arst_halted got %0b want 0", bus.halted); end
    n_checks++; if (bus.retired !== 64'd0) begin n_fail++; $display("FAIL arst_retired got %0d want 0", bus.retired); end
    // W inputs are ignored across an edge while reset is held
    set_w(4'd1, 4'd3, 4'd7, 64'd123, 4'd15, 64'd0);
    bus.d_srcB = 4'd7;
    step();
    rst = 1'b0;
    set_idle();
    #1;
    n_checks++; if (bus.d_rvalB !== 64'd0) begin n_fail++; $display("FAIL rst_hold_r7 got %0d want 0", bus.d_rvalB); end
    n_checks++; if (bus.retired !== 64'd0) begin n_fail++; $display("FAIL rst_hold_retired got %0d want 0", bus.retired); end
  endtask

  task automatic test_ins_stop();
    set_w(4'd0, 4'd3, 4'd8, 64'd5, 4'd15, 64'd0);
    bus.d_srcA = 4'd8;
    step();
    set_idle();
    #1;
    n_checks++; if (bus.stat !== 4'd4) begin n_fail++; $display("FAIL ins_stat got %0d want 4", bus.stat); end
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL ins_halted got %0b want 1", bus.halted); end
    n_checks++; if (bus.d_rvalA !== 64'd0) begin n_fail++; $display("FAIL ins_r8 got %0d want 0", bus.d_rvalA); end
    set_w(4'd2, 4'd0, 4'd15, 64'd0, 4'd15, 64'd0);
    step();
    #1;
    n_checks++; if (bus.stat !== 4'd4) begin n_fail++; $display("FAIL ins_sticky got %0d want 4", bus.stat); end
  endtask

  initial begin
    set_idle();
    bus.d_srcA = 4'd15;
    bus.d_srcB = 4'd15;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write();
    test_dual_write();
    test_bypass();
    test_read_none();
    test_wrap();
    test_halt();
    @(negedge clk);
    test_async_reset();
    test_ins_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
